// File: rtl/value_monitor_pkg.sv
// Shared types and constants for the value_monitor constant-output sink.
package value_monitor_pkg;

  typedef enum logic [1:0] {IDLE, LOCKING, LOCKED, FAULT} mon_state_t;

  localparam int unsigned MY_CONSTANT1 = 10;
  localparam int unsigned MY_CONSTANT2 = 20;
  localparam logic [7:0] MY_OTHER_CONSTANT = 8'(MY_CONSTANT1 + MY_CONSTANT2 + 7);

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over inc.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/value_monitor.sv
// Valid/ready sink that checks each byte against EXPECTED, tracks lock/fault and counts results.
// Optional running signature enabled by defining VALUE_MONITOR_SIG_EN.
module value_monitor
  import value_monitor_pkg::*;
#(
  parameter logic [7:0]  EXPECTED   = MY_OTHER_CONSTANT,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       last_data,
  output logic [7:0]       sig
);

  localparam logic [7:0] LockTarget = 8'(LOCK_COUNT);

  mon_state_t state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [7:0] last_q, last_d;
  logic       locked_q, fault_q;
  logic       xfer, match;

  // Clear forces ready low so a cleared cycle can never also carry a transfer.
  assign in_ready = (state_q != FAULT) && !clear;
  assign xfer     = in_valid && in_ready;
  assign match    = (in_data == EXPECTED);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      last_d  = '0;
    end else if (xfer) begin
      last_d = in_data;
      case (state_q)
        IDLE: begin
          if (match) begin
            run_d   = 8'd1;
            state_d = (LockTarget == 8'd1) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (match) begin
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 == LockTarget) state_d = LOCKED;
          end else begin
            run_d   = '0;
            state_d = IDLE;
          end
        end
        LOCKED: begin
          if (!match) state_d = FAULT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      last_q   <= last_d;
      locked_q <= (state_d == LOCKED);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign locked    = locked_q;
  assign fault     = fault_q;
  assign last_data = last_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (xfer && match),
    .count (match_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_mismatch_cnt (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (xfer && !match),
    .count (mismatch_count)
  );

`ifdef VALUE_MONITOR_SIG_EN
  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (xfer) begin
      sig_d = {sig_q[6:0], sig_q[7]} ^ in_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  assign sig = 8'd0;
`endif

endmodule

// File: tb/tb_value_monitor.sv
// Directed self-checking bench for value_monitor; a second CNT_W=2 instance covers saturation.
module tb_value_monitor;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        clear = 1'b0;

  logic        in_ready, locked, fault;
  logic [15:0] match_count, mismatch_count;
  logic [7:0]  last_data, sig;

  logic        in_ready2, locked2, fault2;
  logic [1:0]  match_count2, mismatch_count2;
  logic [7:0]  last_data2, sig2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  value_monitor #(
    .EXPECTED   (8'd37),
    .LOCK_COUNT (4),
    .CNT_W      (16)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .clear          (clear),
    .locked         (locked),
    .fault          (fault),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .last_data      (last_data),
    .sig            (sig)
  );

  value_monitor #(
    .EXPECTED   (8'd37),
    .LOCK_COUNT (4),
    .CNT_W      (2)
  ) dut2 (
    .clock          (clock),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready2),
    .clear          (clear),
    .locked         (locked2),
    .fault          (fault2),
    .match_count    (match_count2),
    .mismatch_count (mismatch_count2),
    .last_data      (last_data2),
    .sig            (sig2)
  );

  // Presents one byte with valid high across one rising edge; valid stays high between calls.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (locked !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags locked=%b fault=%b required 0 0", locked, fault);
    end
    checks++;
    if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got %0d/%0d required 0/0", match_count, mismatch_count);
    end
    checks++;
    if (last_data !== 8'd0 || sig !== 8'd0) begin
      failures++;
      $display("FAIL reset_data last=%0h sig=%0h required 0 0", last_data, sig);
    end
    rst_n = 1'b1;
    idle_cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) send(8'd37);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_early got %b required 0", locked);
    end
    send(8'd37);
    in_valid = 1'b0;
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_4th got %b required 1", locked);
    end
    checks++;
    if (match_count !== 16'd4 || mismatch_count !== 16'd0) begin
      failures++;
      $display("FAIL lock_counts got %0d/%0d required 4/0", match_count, mismatch_count);
    end
    checks++;
    if (last_data !== 8'd37) begin
      failures++;
      $display("FAIL lock_last got %0d required 37", last_data);
    end
  endtask

  task automatic test_relock();
    logic [7:0] seq [7];
    seq = '{8'd37, 8'd37, 8'd5, 8'd37, 8'd37, 8'd37, 8'd37};
    pulse_clear();
    for (int i = 0; i < 6; i++) send(seq[i]);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_6th got %b required 0", locked);
    end
    send(seq[6]);
    in_valid = 1'b0;
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock_7th got %b required 1", locked);
    end
    checks++;
    if (match_count !== 16'd6 || mismatch_count !== 16'd1) begin
      failures++;
      $display("FAIL relock_counts got %0d/%0d required 6/1", match_count, mismatch_count);
    end
  endtask

  task automatic test_fault();
    send(8'hFF);
    checks++;
    if (fault !== 1'b1 || locked !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fault_enter fault=%b locked=%b ready=%b required 1 0 0",
               fault, locked, in_ready);
    end
    send(8'd37);
    send(8'd9);
    in_valid = 1'b0;
    checks++;
    if (match_count !== 16'd6 || mismatch_count !== 16'd2 || last_data !== 8'hFF) begin
      failures++;
      $display("FAIL fault_hold got %0d/%0d last=%0h required 6/2 ff",
               match_count, mismatch_count, last_data);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_low got %b required 0", in_ready);
    end
    @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || match_count !== 16'd0 || mismatch_count !== 16'd0 ||
        last_data !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fault_clear fault=%b cnt=%0d/%0d last=%0h ready=%b required 0 0/0 0 1",
               fault, match_count, mismatch_count, last_data, in_ready);
    end
  endtask

  task automatic test_clear_race();
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd37;
    @(posedge clock);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (match_count !== 16'd0 || last_data !== 8'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL clear_race cnt=%0d last=%0h locked=%b required 0 0 0",
               match_count, last_data, locked);
    end
    // One match after the race must lock nothing yet but prove the state was IDLE.
    send(8'd37);
    in_valid = 1'b0;
    checks++;
    if (match_count !== 16'd1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL clear_race_after cnt=%0d locked=%b required 1 0", match_count, locked);
    end
  endtask

  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 5; i++) send(8'd37);
    in_valid = 1'b0;
    checks++;
    if (match_count2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_match got %0d required 3", match_count2);
    end
    checks++;
    if (match_count !== 16'd5 || locked !== 1'b1) begin
      failures++;
      $display("FAIL sat_wide cnt=%0d locked=%b required 5 1", match_count, locked);
    end
    send(8'd37);
    in_valid = 1'b0;
    checks++;
    if (match_count2 !== 2'd3 || mismatch_count2 !== 2'd0) begin
      failures++;
      $display("FAIL sat_hold got %0d/%0d required 3/0", match_count2, mismatch_count2);
    end
    // Assert reset between edges while a transfer is being presented.
    in_valid = 1'b1;
    in_data = 8'd37;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (match_count !== 16'd0 || match_count2 !== 2'd0 || locked !== 1'b0 ||
        last_data !== 8'd0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cnt=%0d cnt2=%0d locked=%b last=%0h fault=%b required 0",
               match_count, match_count2, locked, last_data, fault);
    end
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_sig();
    logic [7:0] exp1, exp2;
`ifdef VALUE_MONITOR_SIG_EN
    exp1 = 8'h01;
    exp2 = 8'h00;
`else
    exp1 = 8'h00;
    exp2 = 8'h00;
`endif
    send(8'h01);
    checks++;
    if (sig !== exp1) begin
      failures++;
      $display("FAIL sig_first got %0h required %0h", sig, exp1);
    end
    send(8'h02);
    in_valid = 1'b0;
    checks++;
    if (sig !== exp2) begin
      failures++;
      $display("FAIL sig_second got %0h required %0h", sig, exp2);
    end
    checks++;
    if (mismatch_count !== 16'd2 || last_data !== 8'h02) begin
      failures++;
      $display("FAIL sig_counts mism=%0d last=%0h required 2 02", mismatch_count, last_data);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_relock();
    test_fault();
    test_clear_race();
    test_saturate();
    test_sig();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/value_monitor.md
Name: value_monitor

Overview:
- Receiving end of the 8-bit constant-output interface our generator modules drive on tock_ret.
- Accepts bytes over a valid/ready handshake and compares each against an expected constant.
- Tracks lock and fault status and counts matches and mismatches.
- Used as a self-checking sink in the Metron test harness, downstream of any constant-producing module.

Parameters:
- EXPECTED, 8'd37, reference value (10 + 20 + 7).
- LOCK_COUNT, 4, consecutive matches needed to assert lock; legal range 1..255.
- CNT_W, 16, width of match/mismatch counters.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a byte.
- in_data  input  8  byte under test.
- in_ready  output  1  monitor can accept; a transfer occurs on in_valid && in_ready.
- clear  input  1  synchronous soft clear of state and counters.
- locked  output  1  high in LOCKED state.
- fault  output  1  high in FAULT state.
- match_count  output  CNT_W  accepted bytes equal to EXPECTED.
- mismatch_count  output  CNT_W  accepted bytes not equal to EXPECTED.
- last_data  output  8  most recently accepted byte.
- sig  output  8  running signature (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, run=0, all counters 0, last_data=0, sig=0, locked=0, fault=0.
- in_ready is combinational: 1 when state!=FAULT and clear==0; otherwise 0.
- Outputs are registered. A transfer at edge N is visible on the outputs after edge N.
- On every transfer:
  - last_data<=in_data.
  - match = (in_data==EXPECTED).
  - Increment match_count or mismatch_count accordingly.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- States and transitions, evaluated only on a transfer:
  - IDLE: match -> run=1; go to LOCKED if LOCK_COUNT==1, else LOCKING. Mismatch -> stay in IDLE.
  - LOCKING: match -> run+1; go to LOCKED when run+1==LOCK_COUNT. Mismatch -> IDLE, run=0.
  - LOCKED: match -> stay in LOCKED (run holds). Mismatch -> FAULT.
  - FAULT: no transfers are possible because in_ready=0. Only clear or reset exits FAULT.
- clear=1 in any state:
  - Next state IDLE; run, counters, last_data and sig set to 0.
  - in_ready=0 that cycle, so no transfer occurs and clear never races data.
- in_valid with in_ready=0: nothing changes. The producer must hold data (standard valid/ready rule).
- run is an 8-bit register and never exceeds LOCK_COUNT.
- Reset asserted mid-stream aborts immediately to the reset values. Output glitches during reset assertion are permitted.

Optional Feature:
- Macro: VALUE_MONITOR_SIG_EN.
- Defined: on each transfer, sig <= {sig[6:0],sig[7]} ^ in_data (rotate-left-1 XOR). Cleared by clear and by reset.
- Undefined: sig is tied to 8'd0. The port remains present so the interface is unchanged. No signature register is synthesised.

Decomposition:
- Package value_monitor_pkg holds:
  - typedef enum logic[1:0] {IDLE, LOCKING, LOCKED, FAULT} mon_state_t.
  - localparams MY_CONSTANT1=10, MY_CONSTANT2=20, MY_OTHER_CONSTANT=37, used as the EXPECTED default.
- One natural sub-module: sat_counter (parameter W; inputs inc and clr; output count; saturating). Instantiated twice, for match_count and mismatch_count.

Test Plan:
- Reset, then stream 4 bytes of 37 with valid held high (LOCK_COUNT=4) -> locked=1 after the 4th edge; match_count=4; mismatch_count=0; last_data=37.
- 37, 37, 5, 37, 37, 37, 37 -> run resets at the 5; locked=1 only after the 7th transfer; mismatch_count=1; match_count=6.
- Locked, then send 0xFF -> fault=1 and in_ready=0. Further valid bytes are ignored and counters hold. Pulse clear -> IDLE, all counters 0, in_ready=1.
- clear and in_valid high in the same cycle with data 37 -> no transfer; match_count stays 0; state IDLE.
- CNT_W=2: send 5 matches -> match_count saturates at 3. Assert rst_n low mid-transfer -> all outputs 0 immediately (asynchronous).
- With VALUE_MONITOR_SIG_EN, send 0x01 then 0x02 -> sig=0x01, then 0x00 (0x02^0x02). Without the macro, sig=0 throughout.
